// File: rtl/kws_fbuf_sched.sv
// kws_fbuf_sched: ping-pong scheduler for the KWS input-feature SRAM.
// A frame loader fills one input set while the accelerator drains the other.
// The single SRAM port is shared with round-robin priority under contention.
module kws_fbuf_sched #(
   parameter int ADDR_W    = 14,
   parameter int SET_WORDS = 1168,
   parameter int SET0_BASE = 0,
   parameter int SET1_BASE = 1168
) (
   input  logic              i_ext_pad_clkmux_ehs_clk,
   input  logic              PI_SOC_RST_B,
   input  logic              flush,
   input  logic              wr_valid,
   input  logic [31:0]       wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   output logic              rd_ready,
   output logic [31:0]       rd_data,
   output logic              rd_data_valid,
   output logic              rd_last,
   output logic [1:0]        set_full,
   output logic              wr_set_idx,
   output logic              rd_set_idx,
   output logic              sram_ce,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   output logic [3:0]        sram_bwe,
   input  logic [31:0]       sram_rdata
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FILLING  = 2'd1,
      ST_FULL     = 2'd2,
      ST_DRAINING = 2'd3
   } set_st_e;

   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(SET_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(SET0_BASE);
   localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(SET1_BASE);

   function automatic logic [ADDR_W-1:0] base_of(input logic idx);
      return idx ? BASE1 : BASE0;
   endfunction

   set_st_e           set0_q, set0_d, set1_q, set1_d;
   set_st_e           wr_st, rd_st, wr_new, rd_new;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, wr_addr, rd_addr;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic              rr_pri_q, rr_pri_d;          // 0: writer first, 1: reader first
   logic              rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
   logic              wr_elig, rd_elig, grant_ok, wr_gnt, rd_gnt;

   // Arbitration is purely combinational from registered set state.
   assign wr_st    = wr_idx_q ? set1_q : set0_q;
   assign rd_st    = rd_idx_q ? set1_q : set0_q;
   assign wr_elig  = wr_valid && (wr_st == ST_EMPTY || wr_st == ST_FILLING);
   assign rd_elig  = rd_req && (rd_st == ST_FULL || rd_st == ST_DRAINING);
   // Reset is folded in so that every output reads 0 while it is held.
   assign grant_ok = !flush && !PI_SOC_RST_B;
   assign wr_gnt   = grant_ok && wr_elig && (!rd_elig || !rr_pri_q);
   assign rd_gnt   = grant_ok && rd_elig && (!wr_elig || rr_pri_q);
   assign wr_addr  = base_of(wr_idx_q) + wr_cnt_q;
   assign rd_addr  = base_of(rd_idx_q) + rd_cnt_q;

   assign wr_ready      = wr_gnt;
   assign rd_ready      = rd_gnt;
   assign sram_ce       = wr_gnt || rd_gnt;
   assign sram_we       = wr_gnt;
   assign sram_bwe      = {4{wr_gnt}};
   assign sram_addr     = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : addr_q);
   assign sram_wdata    = wr_gnt ? wr_data : wdata_q;
   assign rd_data_valid = rd_vld_q;
   assign rd_last       = rd_last_q;
   assign rd_data       = rd_vld_q ? sram_rdata : 32'd0;
   assign set_full      = {set1_q == ST_FULL, set0_q == ST_FULL};
   assign wr_set_idx    = wr_idx_q;
   assign rd_set_idx    = rd_idx_q;

   // Next-state for set FSMs, counters, priority and held SRAM bus values.
   always_comb begin
      set0_d    = set0_q;
      set1_d    = set1_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      rr_pri_d  = rr_pri_q;
      addr_d    = sram_addr;
      wdata_d   = sram_wdata;
      rd_vld_d  = 1'b0;
      rd_last_d = 1'b0;
      wr_new    = ST_FILLING;
      rd_new    = ST_DRAINING;
      if (flush) begin
         set0_d   = ST_EMPTY;
         set1_d   = ST_EMPTY;
         wr_cnt_d = '0;
         rd_cnt_d = '0;
         wr_idx_d = 1'b0;
         rd_idx_d = 1'b0;
         addr_d   = '0;
         wdata_d  = '0;
      end else begin
         if (grant_ok && wr_elig && rd_elig) rr_pri_d = ~rr_pri_q;
         if (wr_gnt) begin
            if (wr_cnt_q == LAST_CNT) begin
               wr_new   = ST_FULL;
               wr_cnt_d = '0;
               wr_idx_d = ~wr_idx_q;
            end else begin
               wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            end
            if (wr_idx_q) set1_d = wr_new;
            else          set0_d = wr_new;
         end
         if (rd_gnt) begin
            rd_vld_d  = 1'b1;
            rd_last_d = (rd_cnt_q == LAST_CNT);
            if (rd_cnt_q == LAST_CNT) begin
               rd_new   = ST_EMPTY;
               rd_cnt_d = '0;
               rd_idx_d = ~rd_idx_q;
            end else begin
               rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            end
            if (rd_idx_q) set1_d = rd_new;
            else          set0_d = rd_new;
         end
      end
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
      if (PI_SOC_RST_B) begin
         set0_q    <= ST_EMPTY;
         set1_q    <= ST_EMPTY;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         wr_idx_q  <= 1'b0;
         rd_idx_q  <= 1'b0;
         rr_pri_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
      end else begin
         set0_q    <= set0_d;
         set1_q    <= set1_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         rr_pri_q  <= rr_pri_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_vld_q  <= rd_vld_d;
         rd_last_q <= rd_last_d;
      end
   end

endmodule

// File: tb/tb_kws_fbuf_sched.sv
// Testbench for kws_fbuf_sched: directed vector table, corner sequences and
// randomized traffic against a set-occupancy / FIFO reference model.
module tb_kws_fbuf_sched;

   localparam int AW = 14;
   localparam int SW = 4;
   localparam int B1 = 1168;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0, wr_valid = 1'b0, rd_req = 1'b0;
   logic [31:0]   wr_data = 32'd0;
   logic          wr_ready, rd_ready, rd_data_valid, rd_last;
   logic [31:0]   rd_data, sram_wdata;
   logic [31:0]   sram_rdata = 32'd0;
   logic [1:0]    set_full;
   logic          wr_set_idx, rd_set_idx, sram_ce, sram_we;
   logic [AW-1:0] sram_addr;
   logic [3:0]    sram_bwe;

   kws_fbuf_sched #(.ADDR_W(AW), .SET_WORDS(SW), .SET0_BASE(0), .SET1_BASE(B1)) dut (
      .i_ext_pad_clkmux_ehs_clk(clk), .PI_SOC_RST_B(rst), .flush(flush),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .rd_last(rd_last), .set_full(set_full),
      .wr_set_idx(wr_set_idx), .rd_set_idx(rd_set_idx), .sram_ce(sram_ce),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_bwe(sram_bwe), .sram_rdata(sram_rdata));

   always #5 clk = ~clk;

   // Byte-lane SRAM with one cycle read latency.
   logic [31:0] mem [0:16383];
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_bwe[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-set written/read word counts and one global FIFO of
   // accepted words (sets are filled and drained in the same alternating order).
   int unsigned   m_wc[2], m_rc[2];
   bit            m_wset, m_rset, m_pri;
   logic [31:0]   fifo[$];
   bit            pend, pend_last;
   logic [31:0]   pend_d;
   bit            g_wr, g_rd;
   logic [AW-1:0] g_addr;

   function automatic logic [AW-1:0] mbase(input bit s);
      return s ? AW'(B1) : AW'(0);
   endfunction

   function automatic bit mfull(input int n);
      return (m_wc[n] == SW) && (m_rc[n] == 0);
   endfunction

   task automatic model_clear();
      m_wc[0] = 0; m_wc[1] = 0; m_rc[0] = 0; m_rc[1] = 0;
      m_wset = 1'b0; m_rset = 1'b0;
      fifo.delete();
   endtask

   task automatic model_reset();
      model_clear();
      m_pri = 1'b0;
      pend = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl"}, 64'({wr_ready, rd_ready, sram_ce, sram_we, rd_data_valid, rd_last,
                             set_full, wr_set_idx, rd_set_idx, sram_bwe}), 64'd0);
      chk({nm, "_addr"}, 64'(sram_addr), 64'd0);
      chk({nm, "_wdata"}, 64'(sram_wdata), 64'd0);
      chk({nm, "_rdata"}, 64'(rd_data), 64'd0);
   endtask

   task automatic step(input bit wv, input bit rr, input bit fl, input logic [31:0] wd);
      bit cw, cr, gw, gr;
      @(negedge clk);
      wr_valid = wv; rd_req = rr; flush = fl; wr_data = wd;
      #1;
      chk("rd_data_valid", 64'(rd_data_valid), 64'(pend));
      if (pend) begin
         chk("rd_data", 64'(rd_data), 64'(pend_d));
         chk("rd_last", 64'(rd_last), 64'(pend_last));
      end
      chk("set_full", 64'(set_full), 64'({mfull(1), mfull(0)}));
      chk("wr_set_idx", 64'(wr_set_idx), 64'(m_wset));
      chk("rd_set_idx", 64'(rd_set_idx), 64'(m_rset));
      cw = wv && (m_wc[m_wset] < SW);
      cr = rr && (m_wc[m_rset] == SW);
      gw = !fl && cw && (!cr || !m_pri);
      gr = !fl && cr && (!cw || m_pri);
      chk("wr_ready", 64'(wr_ready), 64'(gw));
      chk("rd_ready", 64'(rd_ready), 64'(gr));
      chk("sram_ce", 64'(sram_ce), 64'(gw || gr));
      if (gw) begin
         chk("wr_addr", 64'(sram_addr), 64'(mbase(m_wset) + AW'(m_wc[m_wset])));
         chk("wr_we_bwe", 64'({sram_we, sram_bwe}), 64'h1F);
         chk("wr_wdata", 64'(sram_wdata), 64'(wd));
      end
      if (gr) begin
         chk("rd_addr", 64'(sram_addr), 64'(mbase(m_rset) + AW'(m_rc[m_rset])));
         chk("rd_we_bwe", 64'({sram_we, sram_bwe}), 64'h00);
      end
      g_wr = wr_ready; g_rd = rd_ready; g_addr = sram_addr;
      pend = 1'b0;
      if (fl) begin
         model_clear();
      end else begin
         if (cw && cr) m_pri = !m_pri;
         if (gw) begin
            fifo.push_back(wd);
            m_wc[m_wset]++;
            if (m_wc[m_wset] == SW) m_wset = !m_wset;
         end
         if (gr) begin
            pend = 1'b1;
            pend_d = (fifo.size() > 0) ? fifo.pop_front() : 32'hDEADBEEF;
            pend_last = (m_rc[m_rset] == SW - 1);
            m_rc[m_rset]++;
            if (m_rc[m_rset] == SW) begin
               m_wc[m_rset] = 0; m_rc[m_rset] = 0;
               m_rset = !m_rset;
            end
         end
      end
   endtask

   task automatic async_reset(input string nm);
      #2 rst = 1'b1;
      #1 chk_zero(nm);
      wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic          wv, rr;
      logic [31:0]   wd;
      logic          e_wrdy, e_rrdy;
      logic [AW-1:0] e_addr;
      logic          e_dv;
      logic [31:0]   e_rdata;
      logic          e_last;
      logic [1:0]    e_full;
      logic          e_widx, e_ridx;
   } vec_t;

   function automatic vec_t mkv(logic wv, logic rr, logic [31:0] wd, logic ew, logic er,
                                logic [AW-1:0] ea, logic edv, logic [31:0] ed, logic el,
                                logic [1:0] ef, logic ewi, logic eri);
      vec_t v;
      v.wv = wv; v.rr = rr; v.wd = wd; v.e_wrdy = ew; v.e_rrdy = er; v.e_addr = ea;
      v.e_dv = edv; v.e_rdata = ed; v.e_last = el; v.e_full = ef; v.e_widx = ewi; v.e_ridx = eri;
      return v;
   endfunction

   vec_t vecs[9];

   initial begin
      vecs[0] = mkv(1'b1, 1'b0, 32'h11223344, 1'b1, 1'b0, 14'd0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
      vecs[1] = mkv(1'b1, 1'b0, 32'h55667788, 1'b1, 1'b0, 14'd1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
      vecs[2] = mkv(1'b1, 1'b0, 32'h99AABBCC, 1'b1, 1'b0, 14'd2, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
      vecs[3] = mkv(1'b1, 1'b0, 32'hDDEEFF00, 1'b1, 1'b0, 14'd3, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
      vecs[4] = mkv(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 14'd0, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0);
      vecs[5] = mkv(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 14'd1, 1'b1, 32'h11223344, 1'b0, 2'b00, 1'b1, 1'b0);
      vecs[6] = mkv(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 14'd2, 1'b1, 32'h55667788, 1'b0, 2'b00, 1'b1, 1'b0);
      vecs[7] = mkv(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 14'd3, 1'b1, 32'h99AABBCC, 1'b0, 2'b00, 1'b1, 1'b0);
      vecs[8] = mkv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 14'd0, 1'b1, 32'hDDEEFF00, 1'b1, 2'b00, 1'b1, 1'b1);

      // Reset state, then directed fill/drain of set 0.
      model_reset();
      repeat (2) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         wr_valid = vecs[i].wv; rd_req = vecs[i].rr; wr_data = vecs[i].wd;
         #1;
         chk("tv_wr_ready", 64'(wr_ready), 64'(vecs[i].e_wrdy));
         chk("tv_rd_ready", 64'(rd_ready), 64'(vecs[i].e_rrdy));
         chk("tv_ce", 64'(sram_ce), 64'(vecs[i].e_wrdy || vecs[i].e_rrdy));
         if (vecs[i].e_wrdy || vecs[i].e_rrdy) begin
            chk("tv_addr", 64'(sram_addr), 64'(vecs[i].e_addr));
            chk("tv_bwe", 64'(sram_bwe), vecs[i].e_wrdy ? 64'hF : 64'h0);
            chk("tv_we", 64'(sram_we), 64'(vecs[i].e_wrdy));
         end
         if (vecs[i].e_wrdy) chk("tv_wdata", 64'(sram_wdata), 64'(vecs[i].wd));
         chk("tv_dv", 64'(rd_data_valid), 64'(vecs[i].e_dv));
         if (vecs[i].e_dv) begin
            chk("tv_rdata", 64'(rd_data), 64'(vecs[i].e_rdata));
            chk("tv_last", 64'(rd_last), 64'(vecs[i].e_last));
         end
         chk("tv_full", 64'(set_full), 64'(vecs[i].e_full));
         chk("tv_widx", 64'(wr_set_idx), 64'(vecs[i].e_widx));
         chk("tv_ridx", 64'(rd_set_idx), 64'(vecs[i].e_ridx));
      end
      chk("byte3_bank", 64'(mem[0][31:24]), 64'h11);

      // Contention: set 0 full, both sides requesting every cycle.
      async_reset("rst_alt");
      for (int i = 0; i < SW; i++) step(1'b1, 1'b0, 1'b0, 32'hA000_0000 + 32'(i));
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b1, 1'b0, $urandom);
         chk("alt_one_grant", 64'({g_wr, g_rd}), (k % 2 == 0) ? 64'b10 : 64'b01);
         chk("alt_addr", 64'(g_addr), (k % 2 == 0) ? 64'(B1 + k / 2) : 64'(k / 2));
      end
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);

      // Both sets full: producer stalls, then resumes at set 0 base.
      async_reset("rst_stall");
      for (int i = 0; i < 2 * SW; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h5A5A_0000 + 32'(i));
         chk("stall_wr_ready", 64'(g_wr), 64'd0);
      end
      for (int i = 0; i < SW; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'hC0FFEE00);
      chk("resume_wr", 64'(g_wr), 64'd1);
      chk("resume_addr", 64'(g_addr), 64'd0);

      // Flush after 2 words into set 1 while a read of set 0 is requested.
      async_reset("rst_flush");
      for (int i = 0; i < SW + 2; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      step(1'b1, 1'b1, 1'b1, 32'h1234_5678);
      chk("flush_no_grant", 64'({g_wr, g_rd}), 64'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      chk("flush_full", 64'(set_full), 64'd0);
      chk("flush_widx", 64'(wr_set_idx), 64'd0);
      chk("flush_dv", 64'(rd_data_valid), 64'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
      chk("flush_wr_addr", 64'(g_addr), 64'd0);

      // Asynchronous reset in the middle of a drain.
      async_reset("rst_pre");
      for (int i = 0; i < SW; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      async_reset("rst_middrain");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'd0);
         chk("post_rst_rd_ready", 64'(g_rd), 64'd0);
      end
      for (int i = 0; i < SW; i++) step(1'b1, 1'b0, 1'b0, $urandom);
      for (int i = 0; i < SW + 1; i++) step(1'b0, 1'b1, 1'b0, 32'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++)
         step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 128) == 0, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
